debug_frame_streamer: RTL and testbench

//  Parametrised successor to the board debug dump path. Snapshots NUM_CH channel words
//  (register file, memory, PC, instruction, cycle count) coherently in one cycle.

---
 rtl/debug_stream_pkg.sv | 27 ++
 rtl/debug_tick_gen.sv | 38 +++
 rtl/debug_frame_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_debug_frame_streamer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_stream_pkg.sv
// ============================================================================
// Module      : debug_stream_pkg
// Description : Shared types and helpers for the debug frame streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    localparam logic [7:0] C_DEFAULT_SYNC_BYTE = 8'hFF;

    // Total bytes on the wire for one frame: sync + sequence + payload (+ checksum).
    function automatic int frame_len(input int num_ch, input int word_bytes, input bit csum_en);
        return 2 + num_ch * word_bytes + (csum_en ? 1 : 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debug_tick_gen.sv
// ============================================================================
// Module      : debug_tick_gen
// Description : Free-running TICK_DIV counter gated by i_auto_en; one-cycle tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_tick_gen #(
    parameter int TICK_DIV = 9000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_auto_en,
    output logic o_tick
);

    localparam int              C_CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(TICK_DIV - 1);

    logic [C_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_auto_en) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_auto_en && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/debug_frame_streamer.sv
// ============================================================================
// Module      : debug_frame_streamer
// Description : Snapshots NUM_CH channel words and streams them as a framed
//               byte packet over valid/ready. Optional trailing XOR checksum
//               enabled by `define DBG_STREAM_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_frame_streamer
    import debug_stream_pkg::*;
#(
    parameter int         NUM_CH     = 20,
    parameter int         WORD_BYTES = 5,
    parameter int         TICK_DIV   = 9000000,
    parameter logic [7:0] SYNC_BYTE  = C_DEFAULT_SYNC_BYTE,
    localparam int        CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             CLK_50,
    input  logic                             RESET,
    input  logic [NUM_CH*WORD_BYTES*8-1:0]   CH_DATA,
    input  logic                             TRIG,
    input  logic                             AUTO_EN,
    input  logic                             CLR_OVR,
    output logic [7:0]                       TX_DATA,
    output logic                             TX_VALID,
    input  logic                             TX_READY,
    output logic                             BUSY,
    output logic [CH_W-1:0]                  CH_SEL,
    output logic                             SNAP_STB,
    output logic [7:0]                       FRAME_CNT,
    output logic                             OVERRUN
);

`ifdef DBG_STREAM_CHECKSUM_EN
    localparam bit C_CSUM_EN = 1'b1;
`else
    localparam bit C_CSUM_EN = 1'b0;
`endif

    localparam int C_FRAME_LEN  = frame_len(NUM_CH, WORD_BYTES, C_CSUM_EN);
    localparam int C_DATA_BYTES = C_FRAME_LEN - 2 - (C_CSUM_EN ? 1 : 0);
    localparam int C_BW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int C_IW         = (C_DATA_BYTES > 1) ? $clog2(C_DATA_BYTES) : 1;

    localparam logic [C_BW-1:0] C_LAST_BYTE = C_BW'(WORD_BYTES - 1);
    localparam logic [C_IW-1:0] C_LAST_IDX  = C_IW'(C_DATA_BYTES - 1);

    state_t          r_state;
    logic [7:0]      r_snap [C_DATA_BYTES];
    logic [C_IW-1:0] r_idx;
    logic [C_BW-1:0] r_byte;
    logic [CH_W-1:0] r_ch;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic            r_busy;
    logic            r_snap_stb;
    logic [7:0]      r_frame_cnt;
    logic            r_ovr;
`ifdef DBG_STREAM_CHECKSUM_EN
    logic [7:0]      r_csum;
`endif

    logic            w_tick;
    logic            w_trigger;
    logic            w_hs;
    logic [C_IW-1:0] w_next_idx;
    logic [7:0]      w_next_byte;

    debug_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (CLK_50),
        .rst_n     (RESET),
        .i_auto_en (AUTO_EN),
        .o_tick    (w_tick)
    );

    assign w_trigger   = TRIG | w_tick;
    assign w_hs        = r_tx_valid & TX_READY;
    assign w_next_idx  = r_idx + 1'b1;
    assign w_next_byte = r_snap[w_next_idx];

    always_ff @(posedge CLK_50) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_byte      <= '0;
            r_ch        <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_snap_stb  <= 1'b0;
            r_frame_cnt <= '0;
            r_ovr       <= 1'b0;
            for (int i = 0; i < C_DATA_BYTES; i++) begin
                r_snap[i] <= '0;
            end
`ifdef DBG_STREAM_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_snap_stb <= 1'b0;

            // A fresh overrun wins over a same-cycle clear.
            if (w_trigger && r_busy) begin
                r_ovr <= 1'b1;
            end else if (CLR_OVR) begin
                r_ovr <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        for (int i = 0; i < C_DATA_BYTES; i++) begin
                            r_snap[i] <= CH_DATA[i*8 +: 8];
                        end
                        r_snap_stb  <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_busy      <= 1'b1;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= SYNC_BYTE;
                        r_state     <= ST_SYNC;
                    end
                end

                ST_SYNC: begin
                    if (w_hs) begin
                        r_tx_data <= r_frame_cnt;
`ifdef DBG_STREAM_CHECKSUM_EN
                        r_csum    <= r_frame_cnt;
`endif
                        r_state   <= ST_SEQ;
                    end
                end

                ST_SEQ: begin
                    if (w_hs) begin
                        r_tx_data <= r_snap[0];
                        r_idx     <= '0;
                        r_byte    <= '0;
                        r_ch      <= '0;
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_hs) begin
`ifdef DBG_STREAM_CHECKSUM_EN
                        r_csum <= r_csum ^ r_tx_data;
`endif
                        if (r_idx == C_LAST_IDX) begin
                            r_idx  <= '0;
                            r_byte <= '0;
                            r_ch   <= '0;
`ifdef DBG_STREAM_CHECKSUM_EN
                            r_tx_data <= r_csum ^ r_tx_data;
                            r_state   <= ST_CSUM;
`else
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= ST_IDLE;
`endif
                        end else begin
                            r_idx     <= w_next_idx;
                            r_tx_data <= w_next_byte;
                            if (r_byte == C_LAST_BYTE) begin
                                r_byte <= '0;
                                r_ch   <= r_ch + 1'b1;
                            end else begin
                                r_byte <= r_byte + 1'b1;
                            end
                        end
                    end
                end

`ifdef DBG_STREAM_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_hs) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`endif

                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_DATA   = r_tx_data;
    assign TX_VALID  = r_tx_valid;
    assign BUSY      = r_busy;
    assign CH_SEL    = r_ch;
    assign SNAP_STB  = r_snap_stb;
    assign FRAME_CNT = r_frame_cnt;
    assign OVERRUN   = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_debug_frame_streamer.sv
// ============================================================================
// Module      : tb_debug_frame_streamer
// Description : Self-checking bench for debug_frame_streamer (NUM_CH=2, W=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_frame_streamer;

    localparam int NUM_CH   = 2;
    localparam int W        = 2;
    localparam int NB       = NUM_CH * W;
    localparam int TICK_DIV = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ch_data;
    logic        trig, auto_en, clr_ovr, tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, snap_stb, overrun;
    logic [0:0]  ch_sel;
    logic [7:0]  frame_cnt;

    debug_frame_streamer #(
        .NUM_CH     (NUM_CH),
        .WORD_BYTES (W),
        .TICK_DIV   (TICK_DIV),
        .SYNC_BYTE  (8'hFF)
    ) dut (
        .CLK_50    (clk),
        .RESET     (rst_n),
        .CH_DATA   (ch_data),
        .TRIG      (trig),
        .AUTO_EN   (auto_en),
        .CLR_OVR   (clr_ovr),
        .TX_DATA   (tx_data),
        .TX_VALID  (tx_valid),
        .TX_READY  (tx_ready),
        .BUSY      (busy),
        .CH_SEL    (ch_sel),
        .SNAP_STB  (snap_stb),
        .FRAME_CNT (frame_cnt),
        .OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the whole frame is queued at trigger time; the head of
    // the queue is what must be on TX_DATA, popped on each accepted byte.
    logic [7:0] m_q[$];
    bit         m_busy, m_ovr, m_stb;
    int         m_pos, m_fc, m_tick;

    always @(posedge clk) begin : model
        bit         t_now;
        logic [7:0] cs;
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_busy = 0; m_ovr = 0; m_stb = 0;
            m_pos = 0; m_fc = 0; m_tick = 0;
        end else begin
            t_now  = trig || (auto_en && m_tick == TICK_DIV - 1);
            m_tick = auto_en ? (m_tick + 1) % TICK_DIV : 0;
            m_stb  = 0;
            if (m_busy) begin
                if (t_now) m_ovr = 1;
                else if (clr_ovr) m_ovr = 0;
                if (tx_ready) begin
                    void'(m_q.pop_front());
                    m_pos++;
                    if (m_q.size() == 0) m_busy = 0;
                end
            end else begin
                if (clr_ovr) m_ovr = 0;
                if (t_now) begin
                    m_fc = (m_fc + 1) % 256;
                    m_q.delete();
                    m_q.push_back(8'hFF);
                    m_q.push_back(8'(m_fc));
                    cs = 8'(m_fc);
                    for (int i = 0; i < NB; i++) begin
                        m_q.push_back(ch_data[i*8 +: 8]);
                        cs ^= ch_data[i*8 +: 8];
                    end
`ifdef DBG_STREAM_CHECKSUM_EN
                    m_q.push_back(cs);
`endif
                    m_busy = 1; m_pos = 0; m_stb = 1;
                end
            end
        end
    end

    logic [7:0] hs_log[$];
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    bit         auto_phase = 0;
    int         last_stb = -1;
    bit         saw_wrap = 0;
    logic [7:0] prev_fc = 8'd0;

    always @(negedge clk) begin : compare
        int e_ch;
        if (chk_en) begin
            e_ch = (m_busy && m_pos >= 2 && m_pos < 2 + NB) ? (m_pos - 2) / W : 0;
            check("tx_valid",  tx_valid,  m_busy);
            check("busy",      busy,      m_busy);
            if (m_busy) check("tx_data", tx_data, m_q[0]);
            check("ch_sel",    ch_sel,    e_ch);
            check("snap_stb",  snap_stb,  m_stb);
            check("frame_cnt", frame_cnt, m_fc);
            check("overrun",   overrun,   m_ovr);
            if (prev_stall) check("stall_hold", tx_data, prev_data);
            if (auto_phase && snap_stb) begin
                if (last_stb >= 0) check("stb_period", cyc - last_stb, TICK_DIV);
                last_stb = cyc;
            end
            if (auto_phase && prev_fc == 8'd255 && frame_cnt == 8'd0) saw_wrap = 1;
            prev_fc = frame_cnt;
        end
        if (rst_n && tx_valid && tx_ready) hs_log.push_back(tx_data);
        prev_stall = rst_n && tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit toggle_ready);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            step();
            if (toggle_ready) tx_ready = ~tx_ready;
            if (!busy) done = 1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        tx_ready = 1'b1;
        step();
    endtask

    // Fixed pattern 32'hDDCC_BBAA: payload XOR cancels, so checksum equals seq.
    task automatic check_frame(input string nm, input logic [7:0] seq);
        logic [7:0] e[$];
        e = '{8'hFF, seq, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef DBG_STREAM_CHECKSUM_EN
        e.push_back(seq);
`endif
        check({nm, "_len"}, hs_log.size(), e.size());
        for (int i = 0; i < e.size() && i < hs_log.size(); i++)
            check(nm, hs_log[i], e[i]);
    endtask

    initial begin
        rst_n = 1'b0; trig = 0; auto_en = 0; clr_ovr = 0; tx_ready = 1;
        ch_data = 32'hDDCC_BBAA;
        step();
        chk_en = 1'b1;
        step();
        check("rst_tx_data",  tx_data,  8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_fc",       frame_cnt, 8'h00);
        rst_n = 1'b1;
        step();

        // Basic frame, always ready.
        hs_log.delete();
        pulse_trig();
        check("first_byte", tx_data, 8'hFF);
        wait_idle(40, 1'b0);
        check_frame("frameA", 8'h01);
        check("busy_after", busy, 1'b0);

        // Same with TX_READY alternating.
        hs_log.delete();
        tx_ready = 1'b0;
        pulse_trig();
        wait_idle(60, 1'b1);
        check_frame("frameB", 8'h02);

        // Trigger during the third byte sets overrun without disturbing the frame.
        hs_log.delete();
        pulse_trig();
        step(); step();
        pulse_trig();
        check("ovr_set", overrun, 1'b1);
        wait_idle(40, 1'b0);
        check_frame("frameC", 8'h03);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("ovr_clr", overrun, 1'b0);

        // Overrun and clear in the same cycle: overrun stays set.
        pulse_trig();
        step();
        trig = 1'b1; clr_ovr = 1'b1;
        step();
        trig = 1'b0; clr_ovr = 1'b0;
        check("ovr_win", overrun, 1'b1);
        wait_idle(40, 1'b0);

        // Reset in the middle of the payload aborts the frame.
        pulse_trig();
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_valid", tx_valid, 1'b0);
        check("rst_mid_fc",    frame_cnt, 8'h00);
        check("rst_mid_ovr",   overrun,  1'b0);
        hs_log.delete();
        pulse_trig();
        wait_idle(40, 1'b0);
        check_frame("frameR", 8'h01);
        check("fc_after_rst", frame_cnt, 8'h01);

        // Random traffic: triggers, backpressure, clears and changing channel data.
        for (int k = 0; k < 600; k++) begin
            trig     = ($urandom_range(0, 5) == 0);
            clr_ovr  = ($urandom_range(0, 15) == 0);
            tx_ready = ($urandom_range(0, 2) != 0);
            ch_data  = $urandom;
            step();
        end
        trig = 0; clr_ovr = 0;
        wait_idle(100, 1'b0);

        // Automatic triggering long enough to wrap the frame counter.
        tx_ready   = 1'b1;
        auto_phase = 1'b1;
        last_stb   = -1;
        auto_en    = 1'b1;
        for (int k = 0; k < 2800; k++) begin
            ch_data = $urandom;
            step();
        end
        auto_en = 1'b0;
        check("fc_wrap_seen", saw_wrap, 1'b1);
        wait_idle(40, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
